// File: rtl/stall_controller.sv
// Pipeline stall/flush controller: load-use bubbles, branch flushes and
// memory-wait freezes with timeout, plus a saturating stall-cycle counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// WARMUP  | post-reset window, ID/EX not yet valid: run PC, flush ID/EX
// RUN     | normal issue; resolves memory wait, branch and load-use
// MEMWAIT | whole pipe frozen until MemReady or the wait times out
module stall_controller #(
  parameter int WARMUP_CYCLES = 1,
  parameter int MEM_TIMEOUT   = 15
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [4:0] IFID_Rs,
  input  logic [4:0] IFID_Rt,
  input  logic       IFID_UsesRt,
  input  logic       IDEX_MemRead,
  input  logic [4:0] IDEX_Rt,
  input  logic       MemReq,
  input  logic       MemReady,
  input  logic       BranchTaken,
  output logic       PCEn,
  output logic       IFIDEn,
  output logic       PipeEn,
  output logic       IFIDFlush,
  output logic       IDEXFlush,
  output logic       MemTimeout,
  output logic [7:0] StallCount
);

  // A zero setting would never leave the state, so both limits floor at 1.
  localparam int WARM_EFF = (WARMUP_CYCLES < 1) ? 1 : WARMUP_CYCLES;
  localparam int TO_EFF   = (MEM_TIMEOUT < 1) ? 1 : MEM_TIMEOUT;
  localparam int WW       = $clog2(WARM_EFF + 1);
  localparam int TW       = $clog2(TO_EFF + 1);

  localparam logic [WW-1:0] WARM_LOAD = WW'(WARM_EFF);
  localparam logic [WW-1:0] WARM_ONE  = WW'(1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TO_EFF - 1);
  localparam logic [TW-1:0] WAIT_ONE  = TW'(1);

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    RUN     = 2'd1,
    MEMWAIT = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] warm_cnt;
  logic [TW-1:0] wait_cnt;
  logic [7:0]    stall_cnt;
  logic          timeout_q;

  logic load_use, mem_wait, wait_expired, stall_inc;
  logic pc_en, ifid_en, pipe_en, ifid_flush, idex_flush;

  assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                    ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
  assign mem_wait     = MemReq && !MemReady;
  assign wait_expired = (wait_cnt >= WAIT_LAST);

  always_comb begin
    state_nxt  = state;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    pipe_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (state)
      WARMUP: begin
        idex_flush = 1'b1;
        if (warm_cnt <= WARM_ONE) state_nxt = RUN;
      end
      RUN: begin
        if (mem_wait) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          pipe_en   = 1'b0;
          state_nxt = MEMWAIT;
        end else if (BranchTaken) begin
          // Wrong-path instruction is discarded, so a pending hazard is moot.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
      MEMWAIT: begin
        if (MemReady) begin
          state_nxt = RUN;
        end else begin
          pc_en   = 1'b0;
          ifid_en = 1'b0;
          pipe_en = 1'b0;
          if (wait_expired) state_nxt = RUN;
        end
      end
      default: begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        pipe_en   = 1'b0;
        state_nxt = WARMUP;
      end
    endcase
    // Reset overrides everything, including an unknown state before the first edge.
    if (!RSTn) begin
      state_nxt  = WARMUP;
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      pipe_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

  assign stall_inc = ((state == RUN) || (state == MEMWAIT)) && !pc_en;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state     <= WARMUP;
      warm_cnt  <= WARM_LOAD;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == WARMUP) && (warm_cnt != '0)) warm_cnt <= warm_cnt - WARM_ONE;
      // Held at zero outside MEMWAIT, so every entry starts a fresh count.
      if (state == MEMWAIT) wait_cnt <= wait_cnt + WAIT_ONE;
      else                  wait_cnt <= '0;
      timeout_q <= (state == MEMWAIT) && !MemReady && wait_expired;
      if (stall_inc && (stall_cnt != 8'hFF)) stall_cnt <= stall_cnt + 8'd1;
    end
  end

  assign PCEn       = pc_en;
  assign IFIDEn     = ifid_en;
  assign PipeEn     = pipe_en;
  assign IFIDFlush  = ifid_flush;
  assign IDEXFlush  = idex_flush;
  assign MemTimeout = timeout_q && RSTn;
  assign StallCount = stall_cnt;

endmodule
